// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the multicycle controller's read/write/fetch strobes.
// Optional build macro MEM_ERR_EN adds address-range and write-collision error reporting.
module mem_responder #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              ir_write,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] instr,
    output logic              mem_ready,
    output logic              busy,
    output logic              mem_err
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP, S_HOLD} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_FE} op_t;

    localparam int          WAIT_M1  = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;
    localparam logic [3:0]  CNT_INIT = WAIT_M1[3:0];

    state_t              r_state, w_state_next;
    logic [3:0]          r_cnt, w_cnt_next;
    op_t                 r_op, w_op;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata, r_instr;
    logic                r_range;
    logic                r_err;
    logic                w_req, w_accept, w_ram_we;
    logic                w_range_err, w_coll;
    logic [DATA_W-1:0]   r_ram [2**ADDR_W];

    assign w_req = mem_read | mem_write | ir_write;

    // Write wins over fetch, fetch wins over read.
    assign w_op = mem_write ? OP_WR : (ir_write ? OP_FE : OP_RD);

`ifdef MEM_ERR_EN
    assign w_range_err = |addr[15:ADDR_W];
    assign w_coll      = mem_write & (mem_read | ir_write);
    assign mem_err     = (r_state == S_RESP) & r_err;
`else
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = |addr[15:ADDR_W];
    assign w_range_err      = 1'b0;
    assign w_coll           = 1'b0;
    assign mem_err          = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = CNT_INIT;
                    w_state_next = (WAIT_CYC == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_ACCESS;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_ACCESS: w_state_next = S_RESP;
            // A strobe still held after completion must not start a second access.
            S_RESP:   w_state_next = w_req ? S_HOLD : S_IDLE;
            S_HOLD:   w_state_next = w_req ? S_HOLD : S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    assign w_ram_we = (r_state == S_ACCESS) && (r_op == OP_WR) && !r_range;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= OP_RD;
            r_idx   <= '0;
            r_wdata <= '0;
            r_range <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_instr <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_op    <= w_op;
                r_idx   <= addr[ADDR_W-1:0];
                r_wdata <= wdata;
                r_range <= w_range_err;
                r_err   <= w_range_err | w_coll;
            end
            if (r_state == S_ACCESS && r_op != OP_WR) begin
                r_rdata <= r_range ? '0 : r_ram[r_idx];
                if (r_op == OP_FE) begin
                    r_instr <= r_range ? '0 : r_ram[r_idx];
                end
            end
        end
    end

    assign rdata     = r_rdata;
    assign instr     = r_instr;
    assign mem_ready = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);

endmodule
